// File: rtl/muldiv_unit.sv
// Iterative 32-bit multiply/divide unit with HI/LO result registers.
// One shift-add or restoring shift-subtract step per clock, then a sign-fix cycle.
module muldiv_unit (
  input  logic        CLK,
  input  logic        RST,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        mthi,
  input  logic        mtlo,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  op_q, op_d;
  logic [31:0] mag_a_q, mag_a_d;
  logic [31:0] mag_b_q, mag_b_d;
  logic        sign_a_q, sign_a_d;
  logic        sign_b_q, sign_b_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [63:0] acc_q, acc_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        done_q, done_d;

  logic        in_sign_a_s, in_sign_b_s;
  logic [31:0] in_mag_a_s, in_mag_b_s;
  logic [32:0] mul_sum_s;
  logic [63:0] mul_step_s;
  logic [32:0] div_rem_sh_s;
  logic [32:0] div_diff_s;
  logic [63:0] div_step_s;
  logic [63:0] prod_fix_s;
  logic [31:0] quot_fix_s;
  logic [31:0] rem_fix_s;
  logic [31:0] a_orig_s;
  logic [31:0] fix_hi_s;
  logic [31:0] fix_lo_s;

  function automatic logic [31:0] cond_neg32(input logic [31:0] v, input logic neg);
    return neg ? (32'd0 - v) : v;
  endfunction

  function automatic logic [63:0] cond_neg64(input logic [63:0] v, input logic neg);
    return neg ? (64'd0 - v) : v;
  endfunction

  // Operand sign/magnitude split at the start edge; unsigned ops never carry a sign.
  always_comb begin
    in_sign_a_s = ~op[0] & src_a[31];
    in_sign_b_s = ~op[0] & src_b[31];
    in_mag_a_s  = cond_neg32(src_a, in_sign_a_s);
    in_mag_b_s  = cond_neg32(src_b, in_sign_b_s);
  end

  // One multiply step (acc = partial product : remaining multiplier) and one divide
  // step (acc = remainder : unconsumed dividend / quotient bits).
  always_comb begin
    mul_sum_s    = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, mag_a_q} : 33'd0);
    mul_step_s   = {mul_sum_s, acc_q[31:1]};
    div_rem_sh_s = {acc_q[63:32], acc_q[31]};
    div_diff_s   = div_rem_sh_s - {1'b0, mag_b_q};
    if (!div_diff_s[32]) begin
      div_step_s = {div_diff_s[31:0], acc_q[30:0], 1'b1};
    end else begin
      div_step_s = {div_rem_sh_s[31:0], acc_q[30:0], 1'b0};
    end
  end

  // Final sign correction and HI/LO selection, including the divide-by-zero result.
  always_comb begin
    prod_fix_s = cond_neg64(acc_q, sign_a_q ^ sign_b_q);
    quot_fix_s = cond_neg32(acc_q[31:0], sign_a_q ^ sign_b_q);
    rem_fix_s  = cond_neg32(acc_q[63:32], sign_a_q);
    a_orig_s   = cond_neg32(mag_a_q, sign_a_q);
    if (!op_q[1]) begin
      fix_hi_s = prod_fix_s[63:32];
      fix_lo_s = prod_fix_s[31:0];
    end else if (mag_b_q == 32'd0) begin
      fix_hi_s = a_orig_s;
      fix_lo_s = 32'hFFFF_FFFF;
    end else begin
      fix_hi_s = rem_fix_s;
      fix_lo_s = quot_fix_s;
    end
  end

  // Next-state and register-update logic for the IDLE/CALC/FIX sequence.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    mag_a_d  = mag_a_q;
    mag_b_d  = mag_b_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d     = op;
          mag_a_d  = in_mag_a_s;
          mag_b_d  = in_mag_b_s;
          sign_a_d = in_sign_a_s;
          sign_b_d = in_sign_b_s;
          cnt_d    = 6'd0;
          acc_d    = op[1] ? {32'd0, in_mag_a_s} : {32'd0, in_mag_b_s};
          state_d  = S_CALC;
        end else begin
          hi_d = mthi ? src_a : hi_q;
          lo_d = mtlo ? src_a : lo_q;
        end
      end
      S_CALC: begin
        acc_d = op_q[1] ? div_step_s : mul_step_s;
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'd31) begin
          state_d = S_FIX;
        end else begin
          state_d = S_CALC;
        end
      end
      S_FIX: begin
        hi_d    = fix_hi_s;
        lo_d    = fix_lo_s;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any operation without touching HI/LO later.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= S_IDLE;
      op_q     <= 2'd0;
      mag_a_q  <= 32'd0;
      mag_b_q  <= 32'd0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      cnt_q    <= 6'd0;
      acc_q    <= 64'd0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      mag_a_q  <= mag_a_d;
      mag_b_q  <= mag_b_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
    end
  end

  assign hi   = hi_q;
  assign lo   = lo_q;
  assign done = done_q;
  assign busy = (state_q != S_IDLE);

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed cases plus randomized operations
// checked against a plain-arithmetic reference model.
module tb_muldiv_unit;

  logic        CLK;
  logic        RST;
  logic        start;
  logic [1:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        mthi;
  logic        mtlo;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;

  int n_cmp = 0;
  int n_bad = 0;

  muldiv_unit dut (
    .CLK   (CLK),
    .RST   (RST),
    .start (start),
    .op    (op),
    .src_a (src_a),
    .src_b (src_b),
    .mthi  (mthi),
    .mtlo  (mtlo),
    .hi    (hi),
    .lo    (lo),
    .busy  (busy),
    .done  (done)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Reference: MIPS-style results from plain signed/unsigned arithmetic.
  function automatic void ref_model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] h, output logic [31:0] l);
    longint      sp;
    logic [63:0] up;
    int          sq;
    int          sr;
    case (o)
      2'b00: begin
        sp = longint'($signed(a)) * longint'($signed(b));
        up = sp;
        h = up[63:32];
        l = up[31:0];
      end
      2'b01: begin
        up = {32'd0, a} * {32'd0, b};
        h = up[63:32];
        l = up[31:0];
      end
      2'b10: begin
        if (b == 32'd0) begin
          h = a; l = 32'hFFFF_FFFF;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          h = 32'd0; l = 32'h8000_0000;
        end else begin
          sq = $signed(a) / $signed(b);
          sr = $signed(a) % $signed(b);
          h = sr; l = sq;
        end
      end
      default: begin
        if (b == 32'd0) begin
          h = a; l = 32'hFFFF_FFFF;
        end else begin
          h = a % b; l = a / b;
        end
      end
    endcase
  endfunction

  // Issue one op from IDLE and watch 40 edges: latency to done, pulse count, busy cycles.
  task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] h, output logic [31:0] l,
                       output int lat, output int npulse, output int nbusy);
    h = 32'hDEAD_BEEF; l = 32'hDEAD_BEEF;
    lat = 0; npulse = 0; nbusy = 0;
    start = 1'b1; op = o; src_a = a; src_b = b; mthi = 1'b0; mtlo = 1'b0;
    @(posedge CLK); #1;
    start = 1'b0; op = 2'($urandom); src_a = $urandom; src_b = $urandom;
    if (busy) nbusy++;
    for (int i = 1; i <= 40; i++) begin
      @(posedge CLK); #1;
      if (done) begin
        npulse++;
        if (lat == 0) begin
          lat = i; h = hi; l = lo;
        end
      end
      if (busy) nbusy++;
    end
  endtask

  task automatic test_reset;
    RST = 1'b1; start = 1'b0; op = 2'd0; src_a = 32'd0; src_b = 32'd0; mthi = 1'b0; mtlo = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    n_cmp++; if ({hi, lo} !== 64'd0) begin n_bad++; $display("FAIL reset_hilo got %h_%h want 0", hi, lo); end
    n_cmp++; if ({busy, done} !== 2'b00) begin n_bad++; $display("FAIL reset_flags got busy=%b done=%b want 0 0", busy, done); end
    RST = 1'b0;
  endtask

  task automatic test_mult;
    logic [31:0] h, l; int lat, np, nb;
    do_op(2'b00, 32'hFFFF_FFFE, 32'd3, h, l, lat, np, nb);
    n_cmp++; if (lat !== 33) begin n_bad++; $display("FAIL mult_latency got %0d want 33", lat); end
    n_cmp++; if (nb !== 33) begin n_bad++; $display("FAIL mult_busy_cycles got %0d want 33", nb); end
    n_cmp++; if (np !== 1) begin n_bad++; $display("FAIL mult_done_pulses got %0d want 1", np); end
    n_cmp++; if ({h, l} !== {32'hFFFF_FFFF, 32'hFFFF_FFFA}) begin n_bad++; $display("FAIL mult_result got %h_%h want ffffffff_fffffffa", h, l); end
  endtask

  task automatic test_multu;
    logic [31:0] h, l; int lat, np, nb;
    do_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, h, l, lat, np, nb);
    n_cmp++; if ({h, l} !== {32'hFFFF_FFFE, 32'h0000_0001}) begin n_bad++; $display("FAIL multu_result got %h_%h want fffffffe_00000001", h, l); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] h, l; int lat, np, nb;
    do_op(2'b10, 32'hFFFF_FFF9, 32'd2, h, l, lat, np, nb);
    n_cmp++; if ({h, l} !== {32'hFFFF_FFFF, 32'hFFFF_FFFD}) begin n_bad++; $display("FAIL div_trunc got %h_%h want ffffffff_fffffffd", h, l); end
    do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, h, l, lat, np, nb);
    n_cmp++; if ({h, l} !== {32'h0000_0000, 32'h8000_0000}) begin n_bad++; $display("FAIL div_overflow got %h_%h want 00000000_80000000", h, l); end
  endtask

  task automatic test_divu_zero;
    logic [31:0] h, l; int lat, np, nb;
    do_op(2'b11, 32'h0000_1234, 32'd0, h, l, lat, np, nb);
    n_cmp++; if (lat !== 33) begin n_bad++; $display("FAIL divz_latency got %0d want 33", lat); end
    n_cmp++; if (np !== 1) begin n_bad++; $display("FAIL divz_done_pulses got %0d want 1", np); end
    n_cmp++; if ({h, l} !== {32'h0000_1234, 32'hFFFF_FFFF}) begin n_bad++; $display("FAIL divz_result got %h_%h want 00001234_ffffffff", h, l); end
  endtask

  task automatic test_busy_ignore;
    int np, lat, extra_busy;
    logic [31:0] h, l;
    np = 0; lat = 0; extra_busy = 0; h = 32'hDEAD_BEEF; l = 32'hDEAD_BEEF;
    start = 1'b1; op = 2'b01; src_a = 32'd5; src_b = 32'd6;
    @(posedge CLK); #1;
    start = 1'b0;
    for (int i = 1; i <= 45; i++) begin
      if (i == 10) begin
        start = 1'b1; op = 2'b10; src_a = 32'h0000_AAAA; src_b = 32'd7; mthi = 1'b1;
      end else begin
        start = 1'b0; mthi = 1'b0;
      end
      @(posedge CLK); #1;
      if (done) begin
        np++;
        if (lat == 0) begin lat = i; h = hi; l = lo; end
      end
      if (i > 33 && busy) extra_busy++;
    end
    n_cmp++; if ({h, l} !== {32'd0, 32'd30}) begin n_bad++; $display("FAIL busy_ign_result got %h_%h want 00000000_0000001e", h, l); end
    n_cmp++; if (np !== 1 || lat !== 33) begin n_bad++; $display("FAIL busy_ign_done got pulses=%0d lat=%0d want 1 33", np, lat); end
    n_cmp++; if (extra_busy !== 0 || hi !== 32'd0) begin n_bad++; $display("FAIL busy_ign_queue got extra_busy=%0d hi=%h want 0 0", extra_busy, hi); end
  endtask

  task automatic test_moves_priority;
    logic [31:0] h, l; int lat, np, nb;
    mthi = 1'b1; mtlo = 1'b1; src_a = 32'hCAFE_0001;
    @(posedge CLK); #1;
    mthi = 1'b0; mtlo = 1'b0;
    n_cmp++; if ({hi, lo} !== {32'hCAFE_0001, 32'hCAFE_0001}) begin n_bad++; $display("FAIL move_both got %h_%h want cafe0001_cafe0001", hi, lo); end
    // start together with moves: the moves are dropped and HI/LO hold during CALC
    start = 1'b1; op = 2'b01; src_a = 32'd7; src_b = 32'd9; mthi = 1'b1; mtlo = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    repeat (20) @(posedge CLK);
    #1;
    n_cmp++; if ({hi, lo} !== {32'hCAFE_0001, 32'hCAFE_0001}) begin n_bad++; $display("FAIL start_prio_hold got %h_%h want cafe0001_cafe0001", hi, lo); end
    repeat (20) @(posedge CLK);
    #1;
    n_cmp++; if ({hi, lo} !== {32'd0, 32'd63}) begin n_bad++; $display("FAIL start_prio_result got %h_%h want 00000000_0000003f", hi, lo); end
  endtask

  task automatic test_reset_mid;
    int np;
    np = 0;
    mthi = 1'b1; mtlo = 1'b1; src_a = 32'h1111_2222;
    @(posedge CLK); #1;
    mthi = 1'b0; mtlo = 1'b0;
    start = 1'b1; op = 2'b11; src_a = 32'hFFFF_0000; src_b = 32'd3;
    @(posedge CLK); #1;
    start = 1'b0;
    repeat (15) @(posedge CLK);
    #1;
    RST = 1'b1;
    #1;
    n_cmp++; if ({hi, lo, busy, done} !== 66'd0) begin n_bad++; $display("FAIL rst_mid_now got hi=%h lo=%h busy=%b done=%b want 0", hi, lo, busy, done); end
    @(posedge CLK); #1;
    RST = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge CLK); #1;
      if (done) np++;
    end
    n_cmp++; if (np !== 0 || {hi, lo} !== 64'd0) begin n_bad++; $display("FAIL rst_mid_after got pulses=%0d hi=%h lo=%h want 0", np, hi, lo); end
    mtlo = 1'b1; src_a = 32'h0000_0055;
    @(posedge CLK); #1;
    mtlo = 1'b0;
    n_cmp++; if ({hi, lo} !== {32'd0, 32'h0000_0055}) begin n_bad++; $display("FAIL rst_mid_mtlo got %h_%h want 00000000_00000055", hi, lo); end
  endtask

  task automatic test_random;
    logic [31:0] a, b, h, l, eh, el; logic [1:0] o; int lat, np, nb, sel;
    for (int k = 0; k < 24; k++) begin
      o = 2'($urandom_range(0, 3));
      a = $urandom;
      if ($urandom_range(0, 5) == 0) a = 32'h8000_0000;
      sel = $urandom_range(0, 7);
      case (sel)
        0: b = 32'd0;
        1: b = 32'hFFFF_FFFF;
        2: b = 32'($urandom_range(1, 15));
        default: b = $urandom;
      endcase
      ref_model(o, a, b, eh, el);
      do_op(o, a, b, h, l, lat, np, nb);
      n_cmp++; if ({h, l} !== {eh, el} || lat !== 33 || np !== 1) begin
        n_bad++;
        $display("FAIL rand_op%0d op=%0d a=%h b=%h got %h_%h lat=%0d pulses=%0d want %h_%h lat=33 pulses=1",
                 k, o, a, b, h, l, lat, np, eh, el);
      end
    end
  endtask

  initial begin
    test_reset;
    test_mult;
    test_multu;
    test_back_to_back;
    test_divu_zero;
    test_busy_ignore;
    test_moves_priority;
    test_reset_mid;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
